layer_compositor: RTL

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

---
 rtl/layer_compositor.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/layer_compositor.sv
// Priority layer compositor with 800x521 raster timing (640x480 visible) and an
// AXI-lite write port that feeds external layer memories and the control registers.
module layer_compositor #(
    parameter int                     LAYER_COUNT = 3,
    parameter int                     COLOR_WIDTH = 12,
    parameter int                     INT_WIDTH   = 16,
    parameter int                     ADDR_WIDTH  = 24,
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     PIX_DIV     = 2,
    parameter logic [COLOR_WIDTH-1:0] KEY         = 12'hFFF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_WIDTH-1:0]              axil_awaddr,
    input  logic [2:0]                         axil_awprot,
    input  logic                               axil_awvalid,
    output logic                               axil_awready,
    input  logic [DATA_WIDTH-1:0]              axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]            axil_wstrb,
    input  logic                               axil_wvalid,
    output logic                               axil_wready,
    output logic [1:0]                         axil_bresp,
    output logic                               axil_bvalid,
    input  logic                               axil_bready,
    output logic [ADDR_WIDTH-8:0]              layer_waddr,
    output logic [DATA_WIDTH-1:0]              layer_wdata,
    output logic [LAYER_COUNT-1:0]             layer_wen,
    output logic                               pix_en,
    output logic [INT_WIDTH-1:0]               x,
    output logic [INT_WIDTH-1:0]               y,
    input  logic [LAYER_COUNT*COLOR_WIDTH-1:0] layer_pixel,
    output logic [COLOR_WIDTH/3-1:0]           red,
    output logic [COLOR_WIDTH/3-1:0]           green,
    output logic [COLOR_WIDTH/3-1:0]           blue,
    output logic                               hsync,
    output logic                               vsync
);

    localparam int CNT_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int CH_W  = COLOR_WIDTH / 3;
    localparam logic [CNT_W-1:0]     PIX_LAST = CNT_W'(PIX_DIV - 1);
    localparam logic [INT_WIDTH-1:0] H_LAST   = INT_WIDTH'(799);
    localparam logic [INT_WIDTH-1:0] V_LAST   = INT_WIDTH'(520);
    localparam logic [INT_WIDTH-1:0] H_VIS    = INT_WIDTH'(640);
    localparam logic [INT_WIDTH-1:0] V_VIS    = INT_WIDTH'(480);
    localparam logic [INT_WIDTH-1:0] HS_START = INT_WIDTH'(656);
    localparam logic [INT_WIDTH-1:0] HS_END   = INT_WIDTH'(751);
    localparam logic [INT_WIDTH-1:0] VS_START = INT_WIDTH'(490);
    localparam logic [INT_WIDTH-1:0] VS_END   = INT_WIDTH'(491);
    localparam logic [4:0]           LAYER_LIMIT = 5'(LAYER_COUNT);
    localparam logic [ADDR_WIDTH-4:0] OFF_MASK = '0;
    localparam logic [ADDR_WIDTH-4:0] OFF_BG   = (ADDR_WIDTH-3)'(1);

    typedef enum logic {IDLE, RESP} axiState_t;

    logic [CNT_W-1:0]       pixCnt_q, pixCnt_d;
    logic                   pixEn_q, pixEn_d;
    logic [INT_WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic [COLOR_WIDTH-1:0] rgb_q, rgb_d;
    logic                   hsync_q, hsync_d, vsync_q, vsync_d;

    axiState_t              state_q;
    logic                   accReady_q;
    logic                   bValid_q;
    logic [1:0]             bResp_q;
    logic [LAYER_COUNT-1:0] wen_q;
    logic [ADDR_WIDTH-8:0]  waddr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [LAYER_COUNT-1:0] mask_q;
    logic [COLOR_WIDTH-1:0] bg_q;

    logic                   isCtrl, idxValid, handshake;
    logic [3:0]             layerIdx;
    logic [ADDR_WIDTH-4:0]  ctrlOffset;
    logic [LAYER_COUNT-1:0] wenHot, maskWr;
    logic [COLOR_WIDTH-1:0] bgWr, composite;
    logic                   visible;
    logic                   unused_ok;

    assign unused_ok = ^{axil_awprot, axil_awaddr[1:0]};

    // Pixel divider and raster counters; x/y only move on the tick.
    always_comb begin
        pixCnt_d = (pixCnt_q == PIX_LAST) ? '0 : pixCnt_q + 1'b1;
        pixEn_d  = (pixCnt_d == PIX_LAST);
        x_d      = x_q;
        y_d      = y_q;
        if (pixEn_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Lowest enabled, non-transparent layer wins; background otherwise.
    always_comb begin
        composite = bg_q;
        for (int k = LAYER_COUNT - 1; k >= 0; k--) begin
            if (mask_q[k] && (layer_pixel[k*COLOR_WIDTH +: COLOR_WIDTH] != KEY))
                composite = layer_pixel[k*COLOR_WIDTH +: COLOR_WIDTH];
        end
        visible = (x_q < H_VIS) && (y_q < V_VIS);
        rgb_d   = pixEn_q ? (visible ? composite : '0) : rgb_q;
        hsync_d = pixEn_q ? !((x_q >= HS_START) && (x_q <= HS_END)) : hsync_q;
        vsync_d = pixEn_q ? !((y_q >= VS_START) && (y_q <= VS_END)) : vsync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixCnt_q <= '0;
            pixEn_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            rgb_q    <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
        end else begin
            pixCnt_q <= pixCnt_d;
            pixEn_q  <= pixEn_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rgb_q    <= rgb_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    // Write decode; control writes merge byte lanes into the current register value.
    always_comb begin
        isCtrl     = axil_awaddr[ADDR_WIDTH-1];
        layerIdx   = axil_awaddr[ADDR_WIDTH-2 -: 4];
        ctrlOffset = axil_awaddr[ADDR_WIDTH-2:2];
        idxValid   = ({1'b0, layerIdx} < LAYER_LIMIT);
        handshake  = accReady_q && axil_awvalid && axil_wvalid;
        wenHot     = '0;
        for (int k = 0; k < LAYER_COUNT; k++) begin
            if ((layerIdx == 4'(k)) && (axil_wstrb != '0))
                wenHot[k] = 1'b1;
        end
        maskWr = mask_q;
        for (int b = 0; b < LAYER_COUNT; b++) begin
            if (axil_wstrb[b/8])
                maskWr[b] = axil_wdata[b];
        end
        bgWr = bg_q;
        for (int b = 0; b < COLOR_WIDTH; b++) begin
            if (axil_wstrb[b/8])
                bgWr[b] = axil_wdata[b];
        end
    end

    // Ready is raised one clk after both valids are seen, so it never fires on a lone channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            accReady_q <= 1'b0;
            bValid_q   <= 1'b0;
            bResp_q    <= 2'b00;
            wen_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            mask_q     <= '1;
            bg_q       <= '0;
        end else begin
            wen_q <= '0;
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        accReady_q <= 1'b0;
                        bValid_q   <= 1'b1;
                        bResp_q    <= 2'b00;
                        state_q    <= RESP;
                        if (isCtrl) begin
                            if (ctrlOffset == OFF_MASK)
                                mask_q <= maskWr;
                            else if (ctrlOffset == OFF_BG)
                                bg_q <= bgWr;
                        end else begin
                            waddr_q <= axil_awaddr[ADDR_WIDTH-6:2];
                            wdata_q <= axil_wdata;
                            wen_q   <= wenHot;
                            if (!idxValid)
                                bResp_q <= 2'b10;
                        end
                    end else begin
                        accReady_q <= axil_awvalid && axil_wvalid && !accReady_q;
                    end
                end
                RESP: begin
                    if (axil_bready) begin
                        bValid_q <= 1'b0;
                        bResp_q  <= 2'b00;
                        state_q  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign axil_awready = accReady_q;
    assign axil_wready  = accReady_q;
    assign axil_bvalid  = bValid_q;
    assign axil_bresp   = bResp_q;
    assign layer_wen    = wen_q;
    assign layer_waddr  = waddr_q;
    assign layer_wdata  = wdata_q;
    assign pix_en       = pixEn_q;
    assign x            = x_q;
    assign y            = y_q;
    assign red          = rgb_q[COLOR_WIDTH-1 -: CH_W];
    assign green        = rgb_q[2*CH_W-1 -: CH_W];
    assign blue         = rgb_q[CH_W-1:0];
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;

endmodule
